regfile_mp: RTL

Parametrised multi-port integer register file for the RISC-V core. It supersedes the fixed 2-read/1-write file.
- NUM_RD read ports and NUM_WR write ports.
- Same-cycle write-to-read bypass on every read port.
- Per-register pending (scoreboard) bits for issue/writeback tracking.
- Sequential post-reset clear of the storage array.
It sits between decode/issue (reads, issue marks) and writeback (writes).

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp_bypass.sv | 43 ++++
 rtl/regfile_mp.sv | 121 ++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam logic        RstEnable   = 1'b0;
  localparam logic        RstDisable  = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bundle between decode-issue, writeback and the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rpend;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     init_busy;

  modport master (
    output we, waddr, wdata, re, raddr, issue_en, issue_addr,
    input  rdata, rpend, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, issue_en, issue_addr,
    output rdata, rpend, init_busy
  );
endinterface

// File: rtl/regfile_mp_bypass.sv
// One read port: same-cycle write forwarding (highest port wins) and pending report.
module regfile_mp_bypass
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]        raddr_i,
  input  logic                     re_i,
  input  logic [DATA_W-1:0]        rword_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic                     pend_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rpend_o
);

  logic              hit;
  logic [DATA_W-1:0] byp_dat;

  always_comb begin
    hit     = 1'b0;
    byp_dat = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_i[k] == WriteEnable && waddr_i[k*ADDR_W +: ADDR_W] == raddr_i) begin
        hit     = 1'b1;
        byp_dat = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdata_o = DATA_W'(ZeroWord);
    rpend_o = 1'b0;
    if (re_i == ReadEnable && raddr_i != '0) begin
      rdata_o = hit ? byp_dat : rword_i;
      rpend_o = pend_i & ~hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, scoreboard bits and post-reset clear.
// Optional REGFILE_TRACE_EN prints every accepted write (simulation only).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                run_en;
  logic [DATA_W-1:0]   rdata_w [NUM_RD];
  logic [NUM_RD-1:0]   rpend_w;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = RUN;
    end
  end

  always_comb begin
    run_en        = (state_q == RUN) && (rst == RstDisable);
    bus.init_busy = (state_q == INIT) || (rst == RstEnable);
  end

  // Later ports overwrite earlier ones, giving highest-index priority.
  always_comb begin
    mem_d = mem_q;
    if (state_q == INIT && rst == RstDisable) mem_d[clr_cnt_q] = '0;
    if (run_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] == WriteEnable && bus.waddr[k*ADDR_W +: ADDR_W] != '0)
          mem_d[bus.waddr[k*ADDR_W +: ADDR_W]] = bus.wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Issue is applied after writeback so a new producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (run_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] == WriteEnable) pend_d[bus.waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (bus.issue_en) pend_d[bus.issue_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) pend_q <= '0;
    else                  pend_q <= pend_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr_w;
    assign raddr_w = bus.raddr[i*ADDR_W +: ADDR_W];

    regfile_mp_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .raddr_i (raddr_w),
      .re_i    (bus.re[i] & run_en),
      .rword_i (mem_q[raddr_w]),
      .we_i    (bus.we),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
      .pend_i  (pend_q[raddr_w]),
      .rdata_o (rdata_w[i]),
      .rpend_o (rpend_w[i])
    );
  end

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NUM_RD; i++) bus.rdata[i*DATA_W +: DATA_W] = rdata_w[i];
    bus.rpend = rpend_w;
  end

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (run_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] == WriteEnable && bus.waddr[k*ADDR_W +: ADDR_W] != '0)
          $display("reg[%d]=%h", bus.waddr[k*ADDR_W +: ADDR_W], bus.wdata[k*DATA_W +: DATA_W]);
      end
    end
  end
`endif

endmodule
